lcd_write_arbiter: RTL and testbench
====================================

Name: lcd_write_arbiter

Overview:
- Owns the 12864 character-LCD parallel bus: lcd_rs, lcd_rw, lcd_en and lcd_dat.
- After reset, runs the fixed power-up init sequence. Then shares the bus between two byte-write requesters, e.g. the binary-row writer and the decimal-row writer.
- Arbitration is round-robin. Each byte is a single write cycle with its own setup, enable-pulse, hold and execution-wait timing.
- Replaces free-running divided-clock strobing with an explicit req/ack handshake.

Parameters:
- T_PWRUP, 2000000: cycles idle after reset before the first init command (40 ms at 50 MHz).
- T_SETUP, 4: cycles rs/dat are stable before lcd_en rises.
- T_EN, 25: cycles lcd_en is held high.
- T_HOLD, 4: cycles rs/dat are held after lcd_en falls.
- T_CMD, 3600: execution wait after a normal write (72 us).
- T_CLEAR, 80000: execution wait after a clear write (rs=0, dat=8'h01), 1.6 ms.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 write request; level, held until ack0
- rs0  in  1  requester 0 register select (0=command, 1=data)
- dat0  in  8  requester 0 byte
- ack0  out  1  one-cycle pulse: requester 0 byte completed
- req1, rs1, dat1, ack1: same as above, for requester 1
- init_done  out  1  high once the init sequence has completed; stays high until reset
- busy  out  1  high whenever state is not IDLE
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; constant 0
- lcd_en  out  1  LCD enable strobe
- lcd_dat  out  8  LCD data bus

Behaviour:
- Reset (asynchronous, immediate, also mid-write):
  - lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_dat=8'h00.
  - ack0=ack1=0, init_done=0, busy=1.
  - State=PWRUP, counter=0, init index=0, last_grant=1.
- States: PWRUP, IDLE, SETUP, EN_HI, HOLD, WAIT. A single 32-bit down-counter times every state.
- PWRUP: lasts T_PWRUP cycles, then loads init command 0 and enters SETUP.
- Init commands, in order, all rs=0: 8'h30, 8'h0C, 8'h01, 8'h06.
  - After WAIT of commands 0-2, load the next command and enter SETUP.
  - After WAIT of command 3, set init_done=1 and enter IDLE.
  - No ack is produced during init. Requests are ignored, not lost: req stays pending.
- IDLE (init_done=1):
  - If only one req is high, grant it.
  - If both are high, grant the one not equal to last_grant, then update last_grant. After reset, req0 therefore wins the first tie.
  - On grant, latch rs/dat from the granted requester into the output registers. Next state is SETUP.
- Write cycle timing:
  - SETUP: T_SETUP cycles, lcd_en=0.
  - EN_HI: T_EN cycles, lcd_en=1.
  - HOLD: T_HOLD cycles, lcd_en=0.
  - WAIT: T_CLEAR cycles if the latched rs=0 and dat=8'h01, else T_CMD cycles.
  - lcd_rs/lcd_dat are constant from the first SETUP cycle through the last WAIT cycle. Input changes during a cycle are ignored.
- Completion:
  - In the last WAIT cycle, the granted ack is high for exactly that one cycle. The state returns to IDLE on the next edge.
  - A req still high in the first IDLE cycle is treated as a new byte. The requester must update rs/dat on the edge where it sees ack.
- Grant-to-ack latency: T_SETUP+T_EN+T_HOLD+wait cycles, counting from the first SETUP cycle.
- Back-to-back: the minimum gap between writes is one IDLE cycle.
- With both requesters held high, grants alternate strictly: 0, 1, 0, 1...
- ack0 and ack1 are never high together. No ack is produced without a prior grant.
- A counter value of 0 for any T_* parameter is treated as 1 cycle.
- busy=0 only in IDLE.

Test Plan (parameters overridden to T_PWRUP=20, T_SETUP=2, T_EN=3, T_HOLD=2, T_CMD=5, T_CLEAR=9):
- Reset release, no requests:
  - After 20 cycles, four enable pulses with lcd_dat=30, 0C, 01, 06 and lcd_rs=0.
  - Enable pulses are 3 cycles wide. The gap after 01 is 9 wait cycles; the others are 5.
  - Then init_done=1, busy=0.
- After init, req1 with rs1=1, dat1=8'h35 held: lcd_rs=1 and lcd_dat=35 for 12 cycles, lcd_en high in cycles 3-5, then a single ack1 pulse in cycle 12 of the write.
- req0 and req1 raised together and kept high, data 41/42: lcd_dat sequence 41, 42, 41, 42. ack0 and ack1 alternate and never overlap.
- req0 with rs0=0, dat0=8'h01: WAIT lasts 9 cycles, ack0 arrives 16 cycles after the first SETUP cycle.
- req0 asserted during PWRUP: no bus activity before the init sequence. The first requester write, 8'hXX, starts in the cycle after init_done rises.
- rst_n pulsed low during EN_HI of a requester write: lcd_en drops to 0 immediately with no ack. The full init sequence reruns before any grant.

Source files
------------

// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - LCD parallel-bus owner: power-up init, then round-robin byte writes
// Every state is timed by one down-counter loaded with (length - 1) on entry.
module lcd_write_arbiter #(
    parameter int unsigned T_PWRUP = 2000000,
    parameter int unsigned T_SETUP = 4,
    parameter int unsigned T_EN    = 25,
    parameter int unsigned T_HOLD  = 4,
    parameter int unsigned T_CMD   = 3600,
    parameter int unsigned T_CLEAR = 80000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] dat0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] dat1,
    output logic       ack1,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_dat
);

    typedef enum logic [2:0] {
        S_PWRUP, S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_WAIT
    } state_t;

    function automatic logic [31:0] load_val(input int unsigned t);
        return (t == 0) ? 32'd0 : 32'(t - 1);
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h30;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    localparam logic [31:0] L_PWRUP = load_val(T_PWRUP);
    localparam logic [31:0] L_SETUP = load_val(T_SETUP);
    localparam logic [31:0] L_EN    = load_val(T_EN);
    localparam logic [31:0] L_HOLD  = load_val(T_HOLD);
    localparam logic [31:0] L_CMD   = load_val(T_CMD);
    localparam logic [31:0] L_CLEAR = load_val(T_CLEAR);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic        init_done_q, init_done_d;
    logic        rs_q, rs_d;
    logic [7:0]  dat_q, dat_d;
    logic        en_q, en_d;
    logic        cnt_done;
    logic        pick;
    logic        wait_last;

    assign cnt_done = (cnt_q == 32'd0);
    // On a tie the requester that was not served last wins.
    assign pick     = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_done ? cnt_q : cnt_q - 32'd1;
        idx_d       = idx_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        init_done_d = init_done_q;
        rs_d        = rs_q;
        dat_d       = dat_q;
        case (state_q)
            S_PWRUP: begin
                if (cnt_done) begin
                    idx_d   = 2'd0;
                    rs_d    = 1'b0;
                    dat_d   = init_cmd(2'd0);
                    cnt_d   = L_SETUP;
                    state_d = S_SETUP;
                end
            end
            S_IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    rs_d    = pick ? rs1 : rs0;
                    dat_d   = pick ? dat1 : dat0;
                    cnt_d   = L_SETUP;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_done) begin
                    cnt_d   = L_EN;
                    state_d = S_EN_HI;
                end
            end
            S_EN_HI: begin
                if (cnt_done) begin
                    cnt_d   = L_HOLD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_done) begin
                    cnt_d   = (!rs_q && dat_q == 8'h01) ? L_CLEAR : L_CMD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_done) begin
                    if (init_done_q) begin
                        state_d = S_IDLE;
                    end else if (idx_q == 2'd3) begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        rs_d    = 1'b0;
                        dat_d   = init_cmd(idx_q + 2'd1);
                        cnt_d   = L_SETUP;
                        state_d = S_SETUP;
                    end
                end
            end
            default: state_d = S_PWRUP;
        endcase
        en_d = (state_d == S_EN_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PWRUP;
            cnt_q       <= L_PWRUP;
            idx_q       <= 2'd0;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            init_done_q <= 1'b0;
            rs_q        <= 1'b0;
            dat_q       <= 8'h00;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            init_done_q <= init_done_d;
            rs_q        <= rs_d;
            dat_q       <= dat_d;
            en_q        <= en_d;
        end
    end

    // Init writes never acknowledge; only requester writes do.
    assign wait_last = (state_q == S_WAIT) && cnt_done && init_done_q;
    assign ack0      = wait_last && !gnt_q;
    assign ack1      = wait_last && gnt_q;
    assign init_done = init_done_q;
    assign busy      = (state_q != S_IDLE);
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = en_q;
    assign lcd_dat   = dat_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb/tb_lcd_write_arbiter.sv - self-checking bench for lcd_write_arbiter
// Expected bus traces are built from transaction lists and phase lengths.
module tb_lcd_write_arbiter;

    localparam int P_PWRUP = 20;
    localparam int P_SETUP = 2;
    localparam int P_EN    = 3;
    localparam int P_HOLD  = 2;
    localparam int P_CMD   = 5;
    localparam int P_CLEAR = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
    logic [7:0] dat0 = 8'h00, dat1 = 8'h00;
    logic       ack0, ack1, init_done, busy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_dat;

    lcd_write_arbiter #(
        .T_PWRUP(P_PWRUP), .T_SETUP(P_SETUP), .T_EN(P_EN),
        .T_HOLD(P_HOLD), .T_CMD(P_CMD), .T_CLEAR(P_CLEAR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .rs0(rs0), .dat0(dat0), .ack0(ack0),
        .req1(req1), .rs1(rs1), .dat1(dat1), .ack1(ack1),
        .init_done(init_done), .busy(busy),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dat(lcd_dat)
    );

    always #5 clk = ~clk;

    // {rw, init_done, busy, ack1, ack0, en, rs, dat}
    typedef logic [14:0] obs_t;

    int         tests_run = 0;
    int         tests_failed = 0;
    obs_t       exp_q[$];
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] cur_bus;
    bit         model_last = 1'b1;
    logic [7:0] init_cmds[4] = '{8'h30, 8'h0C, 8'h01, 8'h06};

    function automatic obs_t mk(bit id, bit bsy, bit a1, bit a0, bit en, logic [8:0] b);
        return {1'b0, id, bsy, a1, a0, en, b};
    endfunction

    function automatic obs_t sample();
        return {lcd_rw, init_done, busy, ack1, ack0, lcd_en, lcd_rs, lcd_dat};
    endfunction

    function automatic void push_n(int n, obs_t o);
        for (int i = 0; i < n; i++) exp_q.push_back(o);
    endfunction

    // who: 0/1 = requester, 2 = init command (never acknowledged)
    function automatic void add_write(int who, logic [8:0] b, bit id);
        int w;
        w = (b == 9'h001) ? P_CLEAR : P_CMD;
        push_n(P_SETUP, mk(id, 1, 0, 0, 0, b));
        push_n(P_EN,    mk(id, 1, 0, 0, 1, b));
        push_n(P_HOLD,  mk(id, 1, 0, 0, 0, b));
        push_n(w - 1,   mk(id, 1, 0, 0, 0, b));
        push_n(1,       mk(id, 1, who == 1, who == 0, 0, b));
        cur_bus = b;
    endfunction

    function automatic void build(bit from_reset);
        logic [8:0] m0[$];
        logic [8:0] m1[$];
        logic [8:0] b;
        int         p;
        m0 = q0;
        m1 = q1;
        exp_q.delete();
        if (from_reset) begin
            model_last = 1'b1;
            cur_bus    = 9'h000;
            push_n(P_PWRUP - 1, mk(0, 1, 0, 0, 0, 9'h000));
            for (int i = 0; i < 4; i++) add_write(2, {1'b0, init_cmds[i]}, 1'b0);
            push_n(1, mk(1, 0, 0, 0, 0, cur_bus));
        end
        while (m0.size() != 0 || m1.size() != 0) begin
            if (m0.size() != 0 && m1.size() != 0) p = model_last ? 0 : 1;
            else p = (m0.size() != 0) ? 0 : 1;
            model_last = p[0];
            b = (p == 1) ? m1.pop_front() : m0.pop_front();
            add_write(p, b, 1'b1);
            push_n(1, mk(1, 0, 0, 0, 0, cur_bus));
        end
        push_n(2, mk(1, 0, 0, 0, 0, cur_bus));
    endfunction

    function automatic void drive();
        if (q0.size() != 0) begin
            req0 = 1'b1;
            {rs0, dat0} = q0[0];
        end else begin
            req0 = 1'b0;
            {rs0, dat0} = 9'($urandom);
        end
        if (q1.size() != 0) begin
            req1 = 1'b1;
            {rs1, dat1} = q1[0];
        end else begin
            req1 = 1'b0;
            {rs1, dat1} = 9'($urandom);
        end
    endfunction

    task automatic run(input bit from_reset, input bit abort_on_en, input string name);
        int   n, nack_exp, nack_obs, fails;
        bit   aborted;
        obs_t o, e;
        nack_exp = 0;
        nack_obs = 0;
        fails    = 0;
        aborted  = 1'b0;
        build(from_reset);
        n = exp_q.size();
        for (int i = 0; i < n; i++) nack_exp += int'(exp_q[i][10]) + int'(exp_q[i][11]);
        if (from_reset) begin
            rst_n = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
        drive();
        if (from_reset) rst_n = 1'b1;
        for (int k = 0; k < n && !aborted; k++) begin
            @(negedge clk);
            o = sample();
            e = exp_q[k];
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                if (fails < 5)
                    $display("FAIL %s cycle %0d: bus {rw,init_done,busy,ack1,ack0,en,rs,dat} got %h expected %h",
                             name, k, o, e);
                fails++;
            end
            if (ack0 === 1'b1) begin
                nack_obs++;
                if (q0.size() != 0) void'(q0.pop_front());
            end
            if (ack1 === 1'b1) begin
                nack_obs++;
                if (q1.size() != 0) void'(q1.pop_front());
            end
            if (abort_on_en && e[9] && e[13]) begin
                #2 rst_n = 1'b0;
                #1;
                o = sample();
                tests_run++;
                if (o !== mk(0, 1, 0, 0, 0, 9'h000)) begin
                    tests_failed++;
                    $display("FAIL %s async reset in EN_HI: got %h expected %h",
                             name, o, mk(0, 1, 0, 0, 0, 9'h000));
                end
                aborted = 1'b1;
            end else begin
                drive();
            end
        end
        if (!aborted) begin
            tests_run++;
            if (nack_obs != nack_exp) begin
                tests_failed++;
                $display("FAIL %s ack count: got %0d expected %0d", name, nack_obs, nack_exp);
            end
        end
    endtask

    task automatic test_reset();
        obs_t o;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        o = sample();
        tests_run++;
        if (o !== mk(0, 1, 0, 0, 0, 9'h000)) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected %h", o, mk(0, 1, 0, 0, 0, 9'h000));
        end
    endtask

    task automatic test_init();
        run(1'b1, 1'b0, "init");
    endtask

    task automatic test_single();
        q1.push_back({1'b1, 8'h35});
        run(1'b0, 1'b0, "single");
    endtask

    task automatic test_back_to_back();
        q0.push_back({1'b1, 8'h41});
        q0.push_back({1'b1, 8'h41});
        q1.push_back({1'b1, 8'h42});
        q1.push_back({1'b1, 8'h42});
        run(1'b0, 1'b0, "tie");
    endtask

    task automatic test_clear();
        q0.push_back({1'b0, 8'h01});
        run(1'b0, 1'b0, "clear");
    endtask

    task automatic test_random();
        int n0, n1;
        for (int it = 0; it < 4; it++) begin
            n0 = $urandom_range(3, 0);
            n1 = (n0 == 0) ? $urandom_range(3, 1) : $urandom_range(3, 0);
            for (int i = 0; i < n0; i++)
                q0.push_back(($urandom_range(3, 0) == 0) ? 9'h001 : 9'($urandom));
            for (int i = 0; i < n1; i++)
                q1.push_back(($urandom_range(3, 0) == 0) ? 9'h001 : 9'($urandom));
            run(1'b0, 1'b0, "random");
        end
    endtask

    task automatic test_pwrup_req();
        q0.push_back(9'($urandom));
        run(1'b1, 1'b0, "pwrup_req");
    endtask

    task automatic test_reset_mid_write();
        q0.push_back(9'($urandom));
        run(1'b1, 1'b1, "reset_mid");
        run(1'b1, 1'b0, "rerun_after_reset");
    endtask

    initial begin
        test_reset();
        test_init();
        test_single();
        test_back_to_back();
        test_clear();
        test_random();
        test_pwrup_req();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
